// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC sequencer. Owns the architectural fetch PC register and selects the next fetch PC
// each cycle from: trap redirect > EXU mispredict redirect > IDU jalr redirect > BPU
// prediction > hold. Raises registered one-cycle flush pulses for the IF/ID and ID/EX
// pipeline registers whenever a redirect is accepted.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   bpu_pc, bpu_jump    static BPU next-PC prediction (bpu_jump is informational only)
//   jalr_valid/_pc      IDU resolved jalr target
//   exu_redirect_*      EXU branch-mispredict correction
//   trap_valid/_pc      trap vector / mepc redirect
//   ifu_ready, stall    IFU acceptance and hazard stall
//   pc, pc_valid        fetch request to the IFU
//   flush_if, flush_id  one-cycle kills of IF/ID and ID/EX
//
// Optional build macro YSYX_22051013_REDIRECT_PERF_EN adds saturating counters
// perf_redirect_cnt (accepted exu + trap) and perf_jalr_cnt (accepted jalr).
module pc_redirect_ctrl #(
    parameter int unsigned        PC_W         = 64,
    parameter logic [PC_W-1:0]    START_PC     = 'h8000_0000,
    parameter int unsigned        DRAIN_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] bpu_pc,
    input  logic            bpu_jump,
    input  logic            jalr_valid,
    input  logic [PC_W-1:0] jalr_pc,
    input  logic            exu_redirect_valid,
    input  logic [PC_W-1:0] exu_redirect_pc,
    input  logic            trap_valid,
    input  logic [PC_W-1:0] trap_pc,
    input  logic            ifu_ready,
    input  logic            stall,
`ifdef YSYX_22051013_REDIRECT_PERF_EN
    output logic [31:0]     perf_redirect_cnt,
    output logic [31:0]     perf_jalr_cnt,
`endif
    output logic [PC_W-1:0] pc,
    output logic            pc_valid,
    output logic            flush_if,
    output logic            flush_id
);

    typedef enum logic [1:0] {StHold, StRun, StPend, StDrain} state_e;
    // Encoded so that numeric order equals redirect priority.
    typedef enum logic [1:0] {SrcNone, SrcJalr, SrcExu, SrcTrap} src_e;

    localparam bit         HasDrain  = (DRAIN_CYCLES != 0);
    // drain_cnt==0 is the last bubble cycle, so load one less than the bubble count.
    localparam logic [2:0] DrainLoad = (DRAIN_CYCLES == 0) ? 3'd0 : 3'(DRAIN_CYCLES - 1);

    state_e          state;
    src_e            pend_src;
    logic [PC_W-1:0] pend_pc;
    logic [2:0]      drain_cnt;

    src_e            req_src;
    logic [PC_W-1:0] req_pc;
    logic            unblocked;
    logic            accept_new;
    logic            latch_pend;
    logic            apply;
    logic [PC_W-1:0] apply_pc;
    src_e            apply_src;

    // The BPU taken bit carries no information we need: bpu_pc is already the chosen target.
    logic unused_bpu_jump;
    assign unused_bpu_jump = bpu_jump;

    assign unblocked = ifu_ready & ~stall;

    // Same-cycle priority pick; lower-priority requests are simply dropped.
    always_comb begin
        req_src = SrcNone;
        req_pc  = '0;
        if (trap_valid) begin
            req_src = SrcTrap;
            req_pc  = trap_pc;
        end else if (exu_redirect_valid) begin
            req_src = SrcExu;
            req_pc  = exu_redirect_pc;
        end else if (jalr_valid) begin
            req_src = SrcJalr;
            req_pc  = jalr_pc;
        end
    end

    // accept_new: a new redirect is taken (flushes pulse next cycle).
    // apply:      the PC register is loaded with a redirect target this edge.
    // latch_pend: a new redirect is parked because the IFU cannot take it yet.
    always_comb begin
        accept_new = 1'b0;
        latch_pend = 1'b0;
        apply      = 1'b0;
        apply_pc   = '0;
        apply_src  = SrcNone;
        unique case (state)
            StRun, StDrain: accept_new = (req_src != SrcNone);
            StPend:         accept_new = (req_src > pend_src);
            default:        accept_new = 1'b0;
        endcase
        if (accept_new) begin
            if (unblocked) begin
                apply     = 1'b1;
                apply_pc  = req_pc;
                apply_src = req_src;
            end else begin
                latch_pend = 1'b1;
            end
        end else if (state == StPend && unblocked) begin
            apply     = 1'b1;
            apply_pc  = pend_pc;
            apply_src = pend_src;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StHold;
            pc        <= START_PC;
            pc_valid  <= 1'b0;
            flush_if  <= 1'b0;
            flush_id  <= 1'b0;
            pend_src  <= SrcNone;
            pend_pc   <= '0;
            drain_cnt <= 3'd0;
        end else begin
            // Flushes fire once per acceptance, including a replacement inside PEND;
            // applying an already-parked redirect does not re-flush.
            flush_if <= accept_new;
            flush_id <= accept_new && (req_src != SrcJalr);

            if (apply) begin
                pc       <= apply_pc;
                pend_src <= SrcNone;
                if (HasDrain) begin
                    state     <= StDrain;
                    pc_valid  <= 1'b0;
                    drain_cnt <= DrainLoad;
                end else begin
                    state    <= StRun;
                    pc_valid <= 1'b1;
                end
            end else if (latch_pend) begin
                state    <= StPend;
                pc_valid <= 1'b0;
                pend_pc  <= req_pc;
                pend_src <= req_src;
            end else begin
                unique case (state)
                    StHold: begin
                        state    <= StRun;
                        pc_valid <= 1'b1;
                        pc       <= START_PC;
                    end
                    StRun: begin
                        if (pc_valid && unblocked) begin
                            pc <= bpu_pc;
                        end
                    end
                    StDrain: begin
                        if (drain_cnt == 3'd0) begin
                            state    <= StRun;
                            pc_valid <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - 3'd1;
                        end
                    end
                    default: begin
                        // StPend waiting on the IFU: hold everything.
                    end
                endcase
            end
        end
    end

`ifdef YSYX_22051013_REDIRECT_PERF_EN
    // Counted on application so a PEND replacement counts only the final source.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_redirect_cnt <= 32'd0;
            perf_jalr_cnt     <= 32'd0;
        end else if (apply) begin
            if (apply_src == SrcJalr) begin
                if (perf_jalr_cnt != 32'hFFFF_FFFF) begin
                    perf_jalr_cnt <= perf_jalr_cnt + 32'd1;
                end
            end else if (perf_redirect_cnt != 32'hFFFF_FFFF) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_apply_src;
    assign unused_apply_src = ^apply_src;
`endif

endmodule
